// File: rtl/ddr3_arb_pkg.sv
// ============================================================================
// Module   : ddr3_arb_pkg
// Purpose  : Shared widths and request record for the two-port DDR3 RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr3_arb_pkg;

   localparam int DDR3_ARB_PORTS  = 2;
   localparam int DDR3_ARB_DATA_W = 128;
   localparam int DDR3_ARB_STRB_W = 16;
   localparam int DDR3_ARB_ID_W   = 16;

   typedef struct packed {
      logic [DDR3_ARB_STRB_W-1:0] wr;
      logic                       rd;
      logic [31:0]                addr;
      logic [DDR3_ARB_DATA_W-1:0] data;
      logic [DDR3_ARB_ID_W-1:0]   id;
   } ddr3_arb_req_t;

   function automatic logic ddr3_arb_has_req(input logic [DDR3_ARB_STRB_W-1:0] wr,
                                             input logic rd);
      return (|wr) | rd;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ddr3_arb_tag_fifo.sv
// ============================================================================
// Module   : ddr3_arb_tag_fifo
// Purpose  : 1-bit port-index FIFO recording the issuing port of each
//            outstanding request; head drives the response demux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_arb_tag_fifo #(
   parameter int DEPTH = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  logic push_data_i,
   input  logic pop_i,
   output logic full_o,
   output logic empty_o,
   output logic head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] mem_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/ddr3_ram_arb.sv
// ============================================================================
// Module   : ddr3_ram_arb
// Purpose  : Two-port round-robin arbiter onto the ddr3_core RAM request port
//            with in-order response routing. DDR3_ARB_FIXED_PRIO_EN selects
//            fixed priority (port 0 wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_ram_arb
   import ddr3_arb_pkg::*;
#(
   parameter int TAG_DEPTH = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [15:0]   p0_wr_i,
   input  logic          p0_rd_i,
   input  logic [31:0]   p0_addr_i,
   input  logic [127:0]  p0_write_data_i,
   input  logic [15:0]   p0_req_id_i,
   output logic          p0_accept_o,
   output logic          p0_ack_o,
   output logic          p0_error_o,
   output logic [127:0]  p0_read_data_o,
   output logic [15:0]   p0_resp_id_o,
   input  logic [15:0]   p1_wr_i,
   input  logic          p1_rd_i,
   input  logic [31:0]   p1_addr_i,
   input  logic [127:0]  p1_write_data_i,
   input  logic [15:0]   p1_req_id_i,
   output logic          p1_accept_o,
   output logic          p1_ack_o,
   output logic          p1_error_o,
   output logic [127:0]  p1_read_data_o,
   output logic [15:0]   p1_resp_id_o,
   output logic [15:0]   ram_wr_o,
   output logic          ram_rd_o,
   output logic [31:0]   ram_addr_o,
   output logic [127:0]  ram_write_data_o,
   output logic [15:0]   ram_req_id_o,
   input  logic          ram_accept_i,
   input  logic          ram_ack_i,
   input  logic          ram_error_i,
   input  logic [127:0]  ram_read_data_i,
   input  logic [15:0]   ram_resp_id_i,
   output logic          tag_err_o
);

   ddr3_arb_req_t req_q, req_d;
   logic          valid_q, valid_d;
   logic          tag_err_q;
   logic          req0, req1, gnt0, gnt1, reg_free;
   logic          tag_full, tag_empty, tag_head, tag_pop;

   assign req0     = ddr3_arb_has_req(p0_wr_i, p0_rd_i);
   assign req1     = ddr3_arb_has_req(p1_wr_i, p1_rd_i);
   assign reg_free = !valid_q || ram_accept_i;

`ifdef DDR3_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reg_free && !tag_full) begin
         gnt0 = req0;
         gnt1 = req1 && !req0;
      end
   end
`else
   logic last_q;

   // last_q=1 means port 1 won most recently, so port 0 wins a tie.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reg_free && !tag_full) begin
         if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         last_q <= 1'b1;
      end else if (gnt0 || gnt1) begin
         last_q <= gnt1;
      end
   end
`endif

   always_comb begin
      valid_d = valid_q;
      req_d   = req_q;
      if (reg_free) begin
         valid_d = gnt0 || gnt1;
         req_d   = '0;
         if (gnt0) begin
            req_d.wr   = p0_wr_i;
            req_d.rd   = p0_rd_i;
            req_d.addr = p0_addr_i;
            req_d.data = p0_write_data_i;
            req_d.id   = p0_req_id_i;
         end else if (gnt1) begin
            req_d.wr   = p1_wr_i;
            req_d.rd   = p1_rd_i;
            req_d.addr = p1_addr_i;
            req_d.data = p1_write_data_i;
            req_d.id   = p1_req_id_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q   <= 1'b0;
         req_q     <= '0;
         tag_err_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         req_q   <= req_d;
         if (ram_ack_i && tag_empty) begin
            tag_err_q <= 1'b1;
         end
      end
   end

   ddr3_arb_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (gnt0 || gnt1),
      .push_data_i (gnt1),
      .pop_i       (tag_pop),
      .full_o      (tag_full),
      .empty_o     (tag_empty),
      .head_o      (tag_head)
   );

   assign tag_pop = ram_ack_i && !tag_empty;

   assign p0_accept_o      = gnt0;
   assign p1_accept_o      = gnt1;
   assign p0_ack_o         = tag_pop && !tag_head;
   assign p1_ack_o         = tag_pop && tag_head;
   assign p0_error_o       = p0_ack_o && ram_error_i;
   assign p1_error_o       = p1_ack_o && ram_error_i;
   assign p0_read_data_o   = p0_ack_o ? ram_read_data_i : '0;
   assign p1_read_data_o   = p1_ack_o ? ram_read_data_i : '0;
   assign p0_resp_id_o     = p0_ack_o ? ram_resp_id_i : '0;
   assign p1_resp_id_o     = p1_ack_o ? ram_resp_id_i : '0;

   assign ram_wr_o         = req_q.wr;
   assign ram_rd_o         = req_q.rd;
   assign ram_addr_o       = req_q.addr;
   assign ram_write_data_o = req_q.data;
   assign ram_req_id_o     = req_q.id;
   assign tag_err_o        = tag_err_q;

endmodule

`default_nettype wire
